// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   UART_DATA_W : default byte width, shared with the uart block
//   arb_state_t : arbiter state encoding (ST_IDLE, ST_LAUNCH, ST_WAIT)
//   rr_next     : round-robin successor of an index, wrapping at n
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } arb_state_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters/uart pins and the transmit arbiter.
//   req, req_data      : per-requester level request and packed bytes
//   gnt                : one-hot grant pulse back to the requesters
//   uart_start/_txin   : start pulse and byte towards the uart
//   uart_txdone        : transmit-done from the uart
//   busy, done, err    : arbiter status
//   owner              : index of the current/last granted requester
// master = client/uart side, slave = arbiter side.
interface uart_tx_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8
);

  logic [NREQ-1:0]         req;
  logic [NREQ*DATA_W-1:0]  req_data;
  logic [NREQ-1:0]         gnt;
  logic                    uart_start;
  logic [DATA_W-1:0]       uart_txin;
  logic                    uart_txdone;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic [$clog2(NREQ)-1:0] owner;

  modport master (
    output req, req_data, uart_txdone,
    input  gnt, uart_start, uart_txin, busy, done, err, owner
  );

  modport slave (
    input  req, req_data, uart_txdone,
    output gnt, uart_start, uart_txin, busy, done, err, owner
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector.
//   req    : request vector
//   ptr    : highest-priority index this round
//   winner : first set request at or after ptr, wrapping modulo NREQ
//   valid  : at least one request is set
module uart_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    valid
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] rot;    // requests rotated so that bit 0 is req[ptr]
  logic [NREQ-1:0] first;  // lowest set bit of rot, one-hot
  logic [NREQ:0]   seen;   // any rot bit below position gi is set
  logic [IW-1:0]   off;
  logic [IW:0]     sum;

  assign seen[0] = 1'b0;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic [IW:0] pos;
    // One extra bit keeps ptr+gi exact before folding back into range;
    // this also covers NREQ values that are not powers of two.
    assign pos        = {1'b0, ptr} + (IW+1)'(gi);
    assign rot[gi]    = (pos >= (IW+1)'(NREQ)) ? req[IW'(pos - (IW+1)'(NREQ))]
                                               : req[IW'(pos)];
    assign first[gi]  = rot[gi] & ~seen[gi];
    assign seen[gi+1] = seen[gi] | rot[gi];
  end

  always_comb begin
    off = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (first[k]) begin
        off = off | IW'(k);
      end
    end
  end

  assign sum    = {1'b0, ptr} + {1'b0, off};
  assign winner = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
  assign valid  = seen[NREQ];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NREQ requesters.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : uart_tx_arbiter_if slave modport (requests, grants, uart pins,
//         status and owner)
// Flow: IDLE picks a winner and latches its byte, LAUNCH issues the start
// pulse and grant for one cycle, WAIT holds the byte until a rising edge of
// uart_txdone (done) or until the watchdog expires (err). Every output is
// registered.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DATA_W  = UART_DATA_W,
  parameter int TIMEOUT = 2048
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  arb_state_t        state_reg;
  logic [IW-1:0]     ptr_reg;
  logic [IW-1:0]     owner_reg;
  logic [DATA_W-1:0] txin_reg;
  logic [NREQ-1:0]   gnt_reg;
  logic              start_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;
  logic              txdone_q_reg;
  logic [CW-1:0]     cnt_reg;

  logic [IW-1:0]     pick_winner;
  logic              pick_valid;
  logic              txdone_rise;
  logic [DATA_W-1:0] req_bytes [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
    assign req_bytes[gi] = bus.req_data[gi*DATA_W +: DATA_W];
  end

  uart_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_reg),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // txdone_q_reg is sampled every cycle, so a level already high when WAIT
  // is entered never looks like a rise.
  assign txdone_rise = bus.uart_txdone & ~txdone_q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      txin_reg     <= '0;
      gnt_reg      <= '0;
      start_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      txdone_q_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      txdone_q_reg <= bus.uart_txdone;
      // Pulse outputs default low; each state raises only what it needs.
      start_reg    <= 1'b0;
      gnt_reg      <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            state_reg <= ST_LAUNCH;
            owner_reg <= pick_winner;
            txin_reg  <= req_bytes[pick_winner];
            start_reg <= 1'b1;
            gnt_reg   <= NREQ'(1) << pick_winner;
            busy_reg  <= 1'b1;
          end
        end

        ST_LAUNCH: begin
          state_reg <= ST_WAIT;
          ptr_reg   <= IW'(rr_next(int'(owner_reg), NREQ));
          cnt_reg   <= '0;
        end

        ST_WAIT: begin
          // A rise on the expiry edge still counts as a normal completion.
          if (txdone_rise) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            err_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_reg;
  assign bus.uart_start = start_reg;
  assign bus.uart_txin  = txin_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.err        = err_reg;
  assign bus.owner      = owner_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NREQ=4, DATA_W=8, TIMEOUT=16).
// A transfer-level reference model predicts every output each cycle; a
// table of directed transfers, a few hand-written corner sequences and a
// randomized phase drive the design.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;
  localparam int IW      = $clog2(NREQ);
  localparam int VW      = NREQ + 1 + DATA_W + 3 + IW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

  uart_tx_arbiter #(
    .NREQ    (NREQ),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // ---------------- reference model ----------------
  // m_phase: 0 = no transfer, 1 = byte being launched, 2 = waiting on uart
  int                m_phase    = 0;
  int                m_ptr      = 0;
  int                m_owner    = 0;
  int                m_wait     = 0;   // WAIT cycles elapsed, counting the current one
  logic [DATA_W-1:0] m_txin     = '0;
  logic              m_txd_prev = 1'b0;
  logic [NREQ-1:0]   e_gnt      = '0;
  logic              e_start    = 1'b0;
  logic              e_busy     = 1'b0;
  logic              e_done     = 1'b0;
  logic              e_err      = 1'b0;

  function automatic int rr_ref(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[IW'((p + k) % NREQ)]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic rise;
    int   w;
    rise       = bus.uart_txdone && !m_txd_prev;
    m_txd_prev = bus.uart_txdone;
    e_gnt   = '0;
    e_start = 1'b0;
    e_done  = 1'b0;
    e_err   = 1'b0;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_owner = 0; m_wait = 0;
      m_txin = '0; m_txd_prev = 1'b0; e_busy = 1'b0;
    end else if (m_phase == 0) begin
      w = rr_ref(bus.req, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_txin  = DATA_W'(bus.req_data >> (w * DATA_W));
        m_phase = 1;
        e_start = 1'b1;
        e_gnt   = NREQ'(1) << w;
        e_busy  = 1'b1;
      end
    end else if (m_phase == 1) begin
      m_ptr   = (m_owner + 1) % NREQ;
      m_phase = 2;
      m_wait  = 1;
    end else begin
      if (rise) begin
        m_phase = 0; e_done = 1'b1; e_busy = 1'b0;
      end else if (m_wait == TIMEOUT) begin
        m_phase = 0; e_err = 1'b1; e_busy = 1'b0;
      end else begin
        m_wait++;
      end
    end
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {bus.gnt, bus.uart_start, bus.uart_txin, bus.busy, bus.done, bus.err, bus.owner};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_cycle();
    logic [VW-1:0] exp_v;
    exp_v = {e_gnt, e_start, m_txin, e_busy, e_done, e_err, IW'(m_owner)};
    checks++;
    if (dut_vec() !== exp_v) begin
      errors++;
      $display("FAIL cycle_outputs @%0d: got gnt/start/txin/busy/done/err/owner=%b/%b/%h/%b/%b/%b/%0d, expected %b/%b/%h/%b/%b/%b/%0d",
               cycle, bus.gnt, bus.uart_start, bus.uart_txin, bus.busy, bus.done, bus.err, bus.owner,
               e_gnt, e_start, m_txin, e_busy, e_done, e_err, m_owner);
    end
  endtask

  // One clock: the model consumes the same inputs as the DUT at the rising
  // edge; outputs are compared at the falling edge, where inputs change.
  task automatic step();
    @(posedge clk);
    model_step();
    cycle++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic wait_for_start(output int n);
    n = 0;
    while (!bus.uart_start && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic wait_for_end(output int n);
    n = 0;
    while (!(bus.done || bus.err) && n < 40) begin
      step();
      n++;
    end
  endtask

  // ---------------- directed transfer table ----------------
  typedef struct {
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] data;
    int                     delay;     // WAIT cycle in which txdone rises, 0 = never
    int                     exp_owner;
    logic [DATA_W-1:0]      exp_txin;
    logic                   exp_err;
    int                     exp_cyc;   // cycles from start pulse to done/err pulse
  } vec_t;

  localparam logic [31:0] D4 = 32'h44332211;
  vec_t vecs [14];

  task automatic run_row(input int idx, input vec_t v);
    int lat;
    int cyc;
    bus.req      = v.req;
    bus.req_data = v.data;
    wait_for_start(lat);
    check($sformatf("row%0d_start", idx), 32'(bus.uart_start), 32'd1);
    check($sformatf("row%0d_latency", idx), 32'(lat), 32'd1);
    check($sformatf("row%0d_owner", idx), 32'(bus.owner), 32'(v.exp_owner));
    check($sformatf("row%0d_gnt", idx), 32'(bus.gnt), 32'(NREQ'(1) << v.exp_owner));
    check($sformatf("row%0d_txin", idx), 32'(bus.uart_txin), 32'(v.exp_txin));
    bus.req = '0;
    cyc = 0;
    while (!(bus.done || bus.err) && cyc < 64) begin
      step();
      cyc++;
      if (cyc == v.delay) bus.uart_txdone = 1'b1;
    end
    check($sformatf("row%0d_outcome", idx), 32'({bus.done, bus.err}), 32'({~v.exp_err, v.exp_err}));
    check($sformatf("row%0d_cycles", idx), 32'(cyc), 32'(v.exp_cyc));
    $display("row %0d: owner=%0d byte=%h %s after %0d cycles", idx, bus.owner, bus.uart_txin,
             bus.err ? "timeout" : "done", cyc);
    bus.uart_txdone = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    int tog_max;

    vecs[0]  = '{4'b1111, D4,            3, 0, 8'h11, 1'b0, 4};
    vecs[1]  = '{4'b1111, D4,            3, 1, 8'h22, 1'b0, 4};
    vecs[2]  = '{4'b1111, D4,            3, 2, 8'h33, 1'b0, 4};
    vecs[3]  = '{4'b1111, D4,            3, 3, 8'h44, 1'b0, 4};
    vecs[4]  = '{4'b1111, D4,            3, 0, 8'h11, 1'b0, 4};
    vecs[5]  = '{4'b1111, D4,            3, 1, 8'h22, 1'b0, 4};
    vecs[6]  = '{4'b1000, D4,            2, 3, 8'h44, 1'b0, 3};
    vecs[7]  = '{4'b1001, D4,            2, 0, 8'h11, 1'b0, 3};  // pointer wrapped to 0
    vecs[8]  = '{4'b1001, D4,            2, 3, 8'h44, 1'b0, 3};
    vecs[9]  = '{4'b0001, 32'h000000A5, 12, 0, 8'hA5, 1'b0, 13}; // inside the 16-cycle watchdog
    vecs[10] = '{4'b0100, D4,            0, 2, 8'h33, 1'b1, TIMEOUT + 1};
    vecs[11] = '{4'b0110, D4,            5, 1, 8'h22, 1'b0, 6};  // pointer is 3 after the timeout
    vecs[12] = '{4'b0001, D4,      TIMEOUT, 0, 8'h11, 1'b0, TIMEOUT + 1}; // rise on expiry edge
    vecs[13] = '{4'b0001, D4,  TIMEOUT - 1, 0, 8'h11, 1'b0, TIMEOUT};

    bus.req         = '0;
    bus.req_data    = '0;
    bus.uart_txdone = 1'b0;
    rst             = 1'b1;
    step();
    step();
    check("reset_state", 32'(dut_vec()), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_row(i, vecs[i]);

    // Reset in the middle of WAIT: transfer vanishes, a later rise is ignored.
    bus.req      = 4'b0010;
    bus.req_data = D4;
    wait_for_start(n);
    check("midrst_start_owner", 32'(bus.owner), 32'd1);
    bus.req = '0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_outputs", 32'(dut_vec()), 32'd0);
    bus.uart_txdone = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      step();
      if (bus.done || bus.err) seen = 1'b1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    bus.uart_txdone = 1'b0;
    step();
    bus.req = 4'b1000;
    wait_for_start(n);
    check("midrst_regrant_owner", 32'(bus.owner), 32'd3);
    bus.req = '0;
    step();
    bus.uart_txdone = 1'b1;
    wait_for_end(n);
    check("midrst_regrant_done", 32'({bus.done, bus.err}), 32'b10);
    $display("midrst: owner=%0d byte=%h done", bus.owner, bus.uart_txin);
    bus.uart_txdone = 1'b0;
    step();

    // txdone stuck high from reset: only a fresh rise inside WAIT completes.
    rst             = 1'b1;
    bus.uart_txdone = 1'b1;
    step();
    rst          = 1'b0;
    bus.req      = 4'b0001;
    bus.req_data = 32'h0000005C;
    wait_for_start(n);
    check("stuck_owner", 32'(bus.owner), 32'd0);
    bus.req = '0;
    seen = 1'b0;
    repeat (5) begin
      step();
      if (bus.done || bus.err) seen = 1'b1;
    end
    bus.uart_txdone = 1'b0;
    repeat (2) begin
      step();
      if (bus.done || bus.err) seen = 1'b1;
    end
    check("stuck_no_early_end", 32'(seen), 32'd0);
    bus.uart_txdone = 1'b1;
    wait_for_end(n);
    check("stuck_rise_done", 32'({bus.done, bus.err}), 32'b10);
    check("stuck_rise_cycles", 32'(n), 32'd1);
    $display("stuck: owner=%0d byte=%h done", bus.owner, bus.uart_txin);
    bus.uart_txdone = 1'b0;
    step();

    // Randomized traffic against the model.
    tog_max = 3;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) tog_max = ($urandom_range(0, 1) == 1) ? 3 : 40;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.gnt[i]) begin
          if ($urandom_range(0, 1) == 1) bus.req[i] = 1'b0;
          else bus.req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        end else if (!bus.req[i]) begin
          if ($urandom_range(0, 7) == 0) begin
            bus.req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            bus.req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 31) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
      if ($urandom_range(0, tog_max) == 0) bus.uart_txdone = ~bus.uart_txdone;
      rst = ($urandom_range(0, 399) == 0);
      step();
      if (bus.done || bus.err)
        $display("rand @%0d: owner=%0d byte=%h %s", cycle, bus.owner, bus.uart_txin,
                 bus.done ? "done" : "timeout");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NREQ requesters using round-robin arbitration.
- Each requester presents a byte with a level request.
- The block sequences the UART through one start pulse per byte, then waits for the rising edge of txdone.
- A watchdog aborts a transfer whose txdone never arrives.
- Sits between client logic and the uart block's start/txin/txdone pins.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 8, byte width; must match the uart txin width
TIMEOUT, 2048, max cycles in WAIT before abort (must be >= 2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req  in  NREQ  per-requester level request
req_data  in  NREQ*DATA_W  packed bytes; requester i uses bits [i*DATA_W +: DATA_W]
gnt  out  NREQ  one-hot one-cycle grant pulse; that byte has been taken
uart_start  out  1  one-cycle start pulse to uart
uart_txin  out  DATA_W  byte to uart; held stable from LAUNCH through WAIT
uart_txdone  in  1  uart transmit-done; level or pulse, only rising edges count
busy  out  1  high in LAUNCH and WAIT
done  out  1  one-cycle pulse when a transfer completes normally
err  out  1  one-cycle pulse when a transfer is aborted by timeout
owner  out  $clog2(NREQ)  index of the current/last granted requester

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, gnt=0, uart_start=0, uart_txin=0, busy=0, done=0, err=0, owner=0.
  - RR pointer=0, so requester 0 has highest priority. txdone_q=0, timeout counter=0.
  - Reset mid-transfer abandons the transfer silently: no done, no err.
- States: IDLE, LAUNCH, WAIT. Encoding is 2 bits.
- IDLE:
  - Each edge with |req=1: pick the first set req at or after the pointer, wrapping modulo NREQ.
  - Same edge: latch req_data of the winner into uart_txin, owner=winner, state->LAUNCH.
  - |req=0: stay in IDLE, outputs quiet.
- LAUNCH (exactly 1 cycle):
  - uart_start=1, gnt[owner]=1, busy=1, counter cleared.
  - Next edge: state->WAIT, pointer=(owner+1) mod NREQ.
- WAIT:
  - busy=1, uart_start=0.
  - txdone_rise = uart_txdone & ~txdone_q; txdone_q is registered every cycle.
  - On an edge with txdone_rise: state->IDLE, done pulses for the following cycle.
  - Otherwise the counter increments; when it reaches TIMEOUT-1 without a rise: state->IDLE, err pulses for the following cycle.
  - A rise on the same edge the counter hits TIMEOUT-1 counts as done; err is not raised.
- Rises of uart_txdone outside WAIT are ignored, including a txdone already high at reset release.
- Pointer:
  - Updated only on LAUNCH->WAIT.
  - Not changed by timeout, reset excepted.
- Latency:
  - req high at IDLE edge k gives uart_start and gnt in cycle k+1.
  - Minimum spacing between consecutive uart_start pulses is 3 + (cycles waiting for txdone) cycles: one IDLE cycle is always inserted.
- Requester rules:
  - req_data must be stable while req=1.
  - After gnt, the requester drops req or presents the next byte by the next IDLE cycle.
  - Dropping req before grant withdraws the request with no side effect.
- uart_txin holds the last byte until the next LAUNCH.

Decomposition:
- Shared package uart_pkg: state encoding constants (ST_IDLE, ST_LAUNCH, ST_WAIT) and the DATA_W default of 8, shared with uart.
- One sub-module, uart_rr_pick: a combinational round-robin selector.
  - Inputs: req and pointer.
  - Outputs: winner index and valid.
  - Unit-testable alone.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'hA5, bench raises uart_txdone 20 cycles after start -> uart_start 1 cycle, gnt=0001, uart_txin=A5 stable until done, done 1 cycle, busy low after.
- All four requesting continuously (bytes 11,22,33,44) -> grant order 0,1,2,3,0,1 and uart_txin sequence 11,22,33,44,11,22; never two grants without an intervening done.
- Pointer wrap: after requester 3 is served, req=4'b1001 -> requester 0 granted next, then 3.
- Timeout with TIMEOUT=16 and txdone held low -> err pulses exactly 16 cycles after entering WAIT; next pending requester is granted afterward; no done.
- Reset mid-WAIT with rst high 1 cycle -> all outputs 0 next cycle, owner=0; a later txdone rise is ignored (no done); req=4'b1000 then granted normally.
- txdone stuck high from reset -> no done until it falls and rises again during WAIT; a rise coincident with the timeout edge yields done, not err.
